// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the seq_det_ctrl serial pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic [DEF_MAX_LEN-1:0] pattern;
    logic [DEF_LEN_W-1:0]   len;
    logic                   overlap;
    logic [DEF_CNT_W-1:0]   window;
  } seq_cfg_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Control/config/data bundle for seq_det_ctrl. SEQ_DET_FIRST_IDX_EN adds first_idx.
interface seq_det_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_window;
  logic               in_valid;
  logic               in;
  logic               out;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;
`ifdef SEQ_DET_FIRST_IDX_EN
  logic [CNT_W-1:0]   first_idx;
`endif

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, in_valid, in,
`ifdef SEQ_DET_FIRST_IDX_EN
    input  first_idx,
`endif
    input  out, busy, done, cfg_err, match_cnt
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, in_valid, in,
`ifdef SEQ_DET_FIRST_IDX_EN
    output first_idx,
`endif
    output out, busy, done, cfg_err, match_cnt
  );
endinterface

// File: rtl/seq_match_core.sv
// Shift history, fill tracking and length-masked pattern compare; hit is combinational per shifted bit.
module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);
  logic [MAX_LEN-1:0] hist, hist_nx, mask;
  logic [LEN_W-1:0]   fill, fill_nx;

  always_comb begin
    hist_nx = {hist[MAX_LEN-2:0], din};
    fill_nx = (fill == len) ? fill : fill + 1'b1;
    mask    = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len)) mask[i] = 1'b1;
    end
    hit = shift_en && (fill_nx == len) && (((hist_nx ^ pattern) & mask) == '0);
  end

  // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nx;
      fill <= (hit && !overlap) ? '0 : fill_nx;
    end
  end
endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the programmable serial pattern detector. Optional SEQ_DET_FIRST_IDX_EN adds first_idx.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input logic           clk,
  input logic           rstn,
  seq_det_ctrl_if.slave bus
);
  seq_state_e       state, state_nx;
  seq_cfg_t         cfg_q;
  logic [CNT_W-1:0] bit_cnt, bit_nx, match_cnt_q;
  logic             out_q, err_q;
  logic             cfg_ok, start_ok, start_bad, consume, hit;

  assign bit_nx = bit_cnt + 1'b1;
  assign cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN)) && (bus.cfg_window != '0);

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nx;
  end

  // abort wins over the window end; a bit presented with abort is dropped.
  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            start_ok = 1'b1;
            state_nx = RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (bus.in_valid) begin
          consume = 1'b1;
          if (bit_nx == cfg_q.window) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rstn),
    .clear    (start_ok),
    .shift_en (consume),
    .din      (bus.in),
    .pattern  (MAX_LEN'(cfg_q.pattern)),
    .len      (LEN_W'(cfg_q.len)),
    .overlap  (cfg_q.overlap),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      cfg_q       <= '0;
      bit_cnt     <= '0;
      match_cnt_q <= '0;
      out_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_q <= hit;
      err_q <= start_bad;
      if (start_ok) begin
        cfg_q.pattern <= DEF_MAX_LEN'(bus.cfg_pattern);
        cfg_q.len     <= DEF_LEN_W'(bus.cfg_len);
        cfg_q.overlap <= bus.cfg_overlap;
        cfg_q.window  <= DEF_CNT_W'(bus.cfg_window);
        bit_cnt       <= '0;
        match_cnt_q   <= '0;
      end
      if (consume) bit_cnt <= bit_nx;
      if (hit && (match_cnt_q != '1)) match_cnt_q <= match_cnt_q + 1'b1;
    end
  end

`ifdef SEQ_DET_FIRST_IDX_EN
  logic [CNT_W-1:0] first_idx_q;

  // Bit positions are 1-based, so zero doubles as "no match yet".
  always_ff @(posedge clk) begin
    if (rstn || start_ok)                 first_idx_q <= '0;
    else if (hit && (first_idx_q == '0)) first_idx_q <= bit_nx;
  end

  assign bus.first_idx = first_idx_q;
`endif

  assign bus.out       = out_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.cfg_err   = err_q;
  assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: behavioural model, directed scenarios, randomized runs.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 scanning, 2 finishing.
  int          m_phase = 0;
  logic [7:0]  m_pat;
  int          m_len, m_win, m_nbits, m_since;
  bit          m_ov;
  bit          hist[$];
  logic        e_out = 0, e_err = 0;
  logic [15:0] e_cnt = 0, e_first = 0;

  function automatic bit model_hit();
    int n = hist.size();
    if ((m_ov ? m_nbits : m_since) < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (hist[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rstn) begin
      m_phase = 0; e_out = 0; e_err = 0; e_cnt = 0; e_first = 0;
    end else begin
      e_out = 0; e_err = 0;
      case (m_phase)
        0: if (bus.start) begin
             if (bus.cfg_len >= 1 && bus.cfg_len <= MAX_LEN && bus.cfg_window != 0) begin
               m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
               m_ov = bus.cfg_overlap; m_win = int'(bus.cfg_window);
               e_cnt = 0; e_first = 0; hist.delete(); m_nbits = 0; m_since = 0;
               m_phase = 1;
             end else e_err = 1;
           end
        1: if (bus.abort) m_phase = 0;
           else if (bus.in_valid) begin
             hist.push_back(bus.in); m_nbits++; m_since++;
             if (model_hit()) begin
               e_out = 1;
               if (e_cnt != 16'hFFFF) e_cnt++;
               if (e_first == 0) e_first = 16'(m_nbits);
               if (!m_ov) m_since = 0;
             end
             if (m_nbits == m_win) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Observation counters for the directed scenarios.
  int fed = 0, n_done = 0, n_dwo = 0;
  int out_pos[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", bus.out, e_out);
      chk("busy", bus.busy, m_phase == 1);
      chk("done", bus.done, m_phase == 2);
      chk("cfg_err", bus.cfg_err, e_err);
      chk("match_cnt", bus.match_cnt, e_cnt);
`ifdef SEQ_DET_FIRST_IDX_EN
      chk("first_idx", bus.first_idx, e_first);
`endif
      if (bus.out) out_pos.push_back(fed);
      if (bus.done) n_done++;
      if (bus.done && bus.out) n_dwo++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [15:0] w);
    bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = ov; bus.cfg_window = w;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic b);
    bus.in_valid = 1'b1; bus.in = b;
    tick();
    fed++;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_dir(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [15:0] w,
                         input logic [15:0] bits, input int nb, input bit gaps);
    out_pos.delete(); n_done = 0; n_dwo = 0; fed = 0;
    do_start(p, l, ov, w);
    for (int i = 0; i < nb; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0; bus.in = 1'($urandom);
        tick();
      end
      feed(bits[nb - 1 - i]);
    end
    tick(); tick();
  endtask

  initial begin
    logic [15:0] cnt_before;
    rstn = 1'b1;
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0; bus.cfg_window = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out", bus.out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    rstn = 1'b0;
    tick();

    // 101 non-overlapping
    run_dir(8'b101, 4'd3, 1'b0, 16'd7, 16'b1010101, 7, 1'b0);
    chk("s1_cnt", bus.match_cnt, 2);
    chk("s1_nout", out_pos.size(), 2);
    if (out_pos.size() == 2) begin
      chk("s1_pos0", out_pos[0], 3);
      chk("s1_pos1", out_pos[1], 7);
    end
    chk("s1_done", n_done, 1);
    chk("s1_done_with_out", n_dwo, 1);
`ifdef SEQ_DET_FIRST_IDX_EN
    chk("s1_first_idx", bus.first_idx, 3);
`endif

    // 101 overlapping
    run_dir(8'b101, 4'd3, 1'b1, 16'd7, 16'b1010101, 7, 1'b0);
    chk("s2_cnt", bus.match_cnt, 3);
    chk("s2_nout", out_pos.size(), 3);
    if (out_pos.size() == 3) begin
      chk("s2_pos0", out_pos[0], 3);
      chk("s2_pos1", out_pos[1], 5);
      chk("s2_pos2", out_pos[2], 7);
    end

    // 110 with gaps
    run_dir(8'b110, 4'd3, 1'b0, 16'd6, 16'b110110, 6, 1'b1);
    chk("s3_cnt", bus.match_cnt, 2);
    chk("s3_nout", out_pos.size(), 2);
    if (out_pos.size() == 2) begin
      chk("s3_pos0", out_pos[0], 3);
      chk("s3_pos1", out_pos[1], 6);
    end

    // Config errors
    do_start(8'b101, 4'd0, 1'b0, 16'd5);
    chk("e1_err", bus.cfg_err, 1);
    chk("e1_busy", bus.busy, 0);
    chk("e1_cnt", bus.match_cnt, 2);
    tick();
    chk("e1_err_off", bus.cfg_err, 0);
    do_start(8'b101, 4'd3, 1'b0, 16'd0);
    chk("e2_err", bus.cfg_err, 1);
    chk("e2_busy", bus.busy, 0);
    chk("e2_cnt", bus.match_cnt, 2);
    tick();

    // Abort after bit 4 of a 10-bit window
    out_pos.delete(); n_done = 0; fed = 0;
    do_start(8'b101, 4'd3, 1'b0, 16'd10);
    feed(1); feed(0); feed(1); feed(1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    tick(); tick(); tick();
    chk("ab_done", n_done, 0);
    chk("ab_cnt", bus.match_cnt, 1);

    // Reset mid-run
    do_start(8'b101, 4'd3, 1'b0, 16'd10);
    feed(1); feed(0); feed(1);
    chk("mr_cnt_pre", bus.match_cnt, 1);
    rstn = 1'b1;
    bus.in_valid = 1'b1; bus.in = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("mr_out", bus.out, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_err", bus.cfg_err, 0);
    chk("mr_cnt", bus.match_cnt, 0);
    rstn = 1'b0;
    tick();

    // Randomized runs with noisy controls and config churn mid-run
    for (int r = 0; r < 60; r++) begin
      logic [3:0]  l;
      logic [15:0] w;
      int          kind;
      kind = int'($urandom_range(0, 9));
      l = 4'($urandom_range(1, MAX_LEN));
      w = 16'($urandom_range(1, 40));
      if (kind == 0) l = 4'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 15));
      if (kind == 1) w = '0;
      if (kind == 2) w = 16'd1;
      do_start(8'($urandom), l, 1'($urandom), w);
      for (int c = 0; c < 200 && m_phase != 0; c++) begin
        bus.in_valid    = ($urandom_range(0, 9) < 7);
        bus.in          = 1'($urandom);
        bus.abort       = ($urandom_range(0, 79) == 0);
        bus.start       = ($urandom_range(0, 15) == 0);
        bus.cfg_pattern = 8'($urandom);
        bus.cfg_len     = 4'($urandom);
        bus.cfg_overlap = 1'($urandom);
        bus.cfg_window  = 16'($urandom_range(0, 40));
        tick();
      end
      bus.in_valid = 0; bus.abort = 0; bus.start = 0;
      chk("rnd_idle", m_phase, 0);
      bus.abort = 1'($urandom);
      tick();
      bus.abort = 0;
    end

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
